// File: rtl/tile_vga_pkg.sv
// Shared constants for the tile VGA engine: default 640x480@60 timing, RGB332 field
// positions and the width helper used to size counters and ports.
package tile_vga_pkg;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;
  localparam int unsigned DefTilePx  = 20;

  localparam int unsigned RMsb = 7;
  localparam int unsigned RLsb = 5;
  localparam int unsigned GMsb = 4;
  localparam int unsigned GLsb = 2;
  localparam int unsigned BMsb = 1;
  localparam int unsigned BLsb = 0;

  // Bits needed to index n items; never less than one so ports stay legal.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tile_framebuffer.sv
// Simple dual-port tile RAM with a registered, read-first read port.
// With double buffering the bank select is the top address bit.
module tile_framebuffer #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  // Both sides use NBAs, so a same-cycle write to rd_addr returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/tile_vga_engine.sv
// Tile-based VGA engine: timing counters, divider-free tile addressing, optional
// double-buffered framebuffer swapped in vertical blanking, two-stage pixel pipeline.
module tile_vga_engine import tile_vga_pkg::*; #(
  parameter int unsigned H_ACTIVE   = DefHActive,
  parameter int unsigned H_FP       = DefHFp,
  parameter int unsigned H_SYNC     = DefHSync,
  parameter int unsigned H_BP       = DefHBp,
  parameter int unsigned V_ACTIVE   = DefVActive,
  parameter int unsigned V_FP       = DefVFp,
  parameter int unsigned V_SYNC     = DefVSync,
  parameter int unsigned V_BP       = DefVBp,
  parameter int unsigned TILE_PX    = DefTilePx,
  parameter int unsigned DOUBLE_BUF = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wr_en,
  input  logic [width_of(H_ACTIVE/TILE_PX)-1:0] wr_x,
  input  logic [width_of(V_ACTIVE/TILE_PX)-1:0] wr_y,
  input  logic [7:0]                            wr_data,
  input  logic                                  swap_req,
  output logic                                  swap_pending,
  output logic                                  frame_start,
  output logic                                  hsync,
  output logic                                  vsync,
  output logic [3:0]                            red,
  output logic [3:0]                            green,
  output logic [3:0]                            blue
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned TILES_X = H_ACTIVE / TILE_PX;
  localparam int unsigned TILES_Y = V_ACTIVE / TILE_PX;
  localparam int unsigned XW      = width_of(TILES_X);
  localparam int unsigned YW      = width_of(TILES_Y);
  localparam int unsigned ADDR_W  = width_of(TILES_X * TILES_Y);
  localparam int unsigned RAM_AW  = ADDR_W + DOUBLE_BUF;
  localparam int unsigned HCW     = width_of(H_TOTAL + 1);
  localparam int unsigned VCW     = width_of(V_TOTAL + 1);
  localparam int unsigned PXW     = width_of(TILE_PX);

  logic [HCW-1:0]    hc_q, hc_d;
  logic [VCW-1:0]    vc_q, vc_d;
  logic [PXW-1:0]    px_q, px_d, ly_q, ly_d;
  logic [XW-1:0]     tx_q, tx_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              disp_bank_q, disp_bank_d;
  logic              swap_pending_q, swap_pending_d;
  logic              swap_req_q;
  logic [RAM_AW-1:0] rd_addr, wr_addr, rd_addr_q;
  logic [ADDR_W-1:0] rd_tile, wr_tile;
  logic              act1_q, hs1_q, vs1_q, act2_q, hs2_q, vs2_q;
  logic              line_end, frame_end, active, hs_raw, vs_raw;
  logic              swap_edge, swap_point, wr_ok;
  logic [7:0]        pix;

  assign line_end  = (hc_q == HCW'(H_TOTAL - 1));
  assign frame_end = line_end && (vc_q == VCW'(V_TOTAL - 1));
  assign active    = (hc_q < HCW'(H_ACTIVE)) && (vc_q < VCW'(V_ACTIVE));
  assign hs_raw    = !((hc_q >= HCW'(H_ACTIVE + H_FP)) &&
                       (hc_q <  HCW'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_raw    = !((vc_q >= VCW'(V_ACTIVE + V_FP)) &&
                       (vc_q <  VCW'(V_ACTIVE + V_FP + V_SYNC)));

  always_comb begin
    hc_d       = line_end ? '0 : hc_q + 1'b1;
    vc_d       = vc_q;
    px_d       = px_q + 1'b1;
    tx_d       = tx_q;
    ly_d       = ly_q;
    row_base_d = row_base_q;
    if (px_q == PXW'(TILE_PX - 1)) begin
      px_d = '0;
      tx_d = tx_q + 1'b1;
    end
    if (line_end) begin
      vc_d = frame_end ? '0 : vc_q + 1'b1;
      px_d = '0;
      tx_d = '0;
      ly_d = ly_q + 1'b1;
      // row_base tracks ty*TILES_X; it free-runs through blanking and is masked there
      if (ly_q == PXW'(TILE_PX - 1)) begin
        ly_d       = '0;
        row_base_d = row_base_q + ADDR_W'(TILES_X);
      end
      if (frame_end) begin
        ly_d       = '0;
        row_base_d = '0;
      end
    end
  end

  assign swap_edge  = swap_req & ~swap_req_q;
  assign swap_point = (hc_q == '0) && (vc_q == VCW'(V_ACTIVE));

  always_comb begin
    disp_bank_d    = disp_bank_q;
    swap_pending_d = swap_pending_q;
    if (DOUBLE_BUF != 0) begin
      if (swap_point && (swap_pending_q || swap_edge)) begin
        disp_bank_d    = ~disp_bank_q;
        swap_pending_d = 1'b0;
      end else if (swap_edge) begin
        swap_pending_d = 1'b1;
      end
    end
  end

  assign rd_tile = row_base_q + ADDR_W'(tx_q);
  assign wr_tile = ADDR_W'(wr_y) * ADDR_W'(TILES_X) + ADDR_W'(wr_x);
  assign wr_ok   = wr_en && ({1'b0, wr_x} < (XW + 1)'(TILES_X)) &&
                   ({1'b0, wr_y} < (YW + 1)'(TILES_Y));

  if (DOUBLE_BUF != 0) begin : g_dbuf
    assign rd_addr = {disp_bank_q, rd_tile};
    assign wr_addr = {~disp_bank_q, wr_tile};
  end else begin : g_sbuf
    assign rd_addr = rd_tile;
    assign wr_addr = wr_tile;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hc_q           <= '0;
      vc_q           <= '0;
      px_q           <= '0;
      tx_q           <= '0;
      ly_q           <= '0;
      row_base_q     <= '0;
      disp_bank_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_req_q     <= 1'b0;
      rd_addr_q      <= '0;
      act1_q         <= 1'b0;
      hs1_q          <= 1'b1;
      vs1_q          <= 1'b1;
      act2_q         <= 1'b0;
      hs2_q          <= 1'b1;
      vs2_q          <= 1'b1;
    end else begin
      hc_q           <= hc_d;
      vc_q           <= vc_d;
      px_q           <= px_d;
      tx_q           <= tx_d;
      ly_q           <= ly_d;
      row_base_q     <= row_base_d;
      disp_bank_q    <= disp_bank_d;
      swap_pending_q <= swap_pending_d;
      swap_req_q     <= swap_req;
      rd_addr_q      <= rd_addr;
      act1_q         <= active;
      hs1_q          <= hs_raw;
      vs1_q          <= vs_raw;
      act2_q         <= act1_q;
      hs2_q          <= hs1_q;
      vs2_q          <= vs1_q;
    end
  end

  tile_framebuffer #(
    .AW (RAM_AW),
    .DW (8)
  ) u_fb (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr_q),
    .rd_data (pix)
  );

  // Counters sit at 0,0 while held in reset, so the pulse is gated by rst.
  assign frame_start  = rst && (hc_q == '0) && (vc_q == '0);
  assign swap_pending = swap_pending_q;
  assign hsync        = hs2_q;
  assign vsync        = vs2_q;
  assign red   = act2_q ? {pix[RMsb:RLsb], pix[RMsb]} : 4'h0;
  assign green = act2_q ? {pix[GMsb:GLsb], pix[GMsb]} : 4'h0;
  assign blue  = act2_q ? {pix[BMsb:BLsb], pix[BMsb:BLsb]} : 4'h0;

endmodule
